// File: rtl/tick_timekeeper.sv
// Alarm clock: BCD time-of-day driven by 1/100 s ticks, alarm FSM with snooze and ring timeout.
// Latency: all outputs registered, one edge after the qualifying input; no backpressure (pulse/level inputs).
module tick_timekeeper #(
  parameter int SNOOZE_MIN = 5,
  parameter int RING_SEC   = 60
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       hundrethSec,
  input  logic       set_en,
  input  logic [7:0] set_hr,
  input  logic [7:0] set_min,
  input  logic       alarm_wr,
  input  logic [7:0] alarm_hr,
  input  logic [7:0] alarm_min,
  input  logic       alarm_arm,
  input  logic       snooze,
  input  logic       alarm_off,
  output logic [7:0] hr,
  output logic [7:0] min,
  output logic [7:0] sec,
  output logic [7:0] hsec,
  output logic       ringing,
  output logic [1:0] state
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ARMED   = 2'd1,
    S_RINGING = 2'd2,
    S_SNOOZE  = 2'd3
  } state_t;

  localparam logic [15:0] SNZ_LOAD  = 16'(SNOOZE_MIN * 60);
  localparam logic [15:0] RING_LOAD = 16'(RING_SEC);

  function automatic logic [7:0] bcd_inc(input logic [7:0] v);
    if (v[3:0] == 4'd9) return {v[7:4] + 4'd1, 4'd0};
    else                return {v[7:4], v[3:0] + 4'd1};
  endfunction

  function automatic logic hm_ok(input logic [7:0] h, input logic [7:0] m);
    return (h[3:0] <= 4'd9) && (h[7:4] <= 4'd9) && (m[3:0] <= 4'd9) &&
           (m[7:4] <= 4'd9) && (h <= 8'h23) && (m <= 8'h59);
  endfunction

  logic [7:0]  r_hr, r_min, r_sec, r_hsec;
  logic [7:0]  r_alm_hr, r_alm_min;
  state_t      r_state;
  logic [15:0] r_ring_cnt, r_snz_cnt;
  logic        r_ringing;

  logic [7:0]  w_nxt_hr, w_nxt_min, w_nxt_sec, w_nxt_hsec;
  logic        w_hsec_wrap, w_sec_wrap, w_min_wrap;
  logic        w_sec_carry, w_set_load, w_alm_load, w_match;
  state_t      w_state_nxt;
  logic [15:0] w_ring_nxt, w_snz_nxt;

  // Whole carry chain resolves in one cycle so 23:59:59.99 wraps straight to midnight.
  always_comb begin
    w_hsec_wrap = (r_hsec == 8'h99);
    w_sec_wrap  = w_hsec_wrap && (r_sec == 8'h59);
    w_min_wrap  = w_sec_wrap && (r_min == 8'h59);
    w_nxt_hsec  = w_hsec_wrap ? 8'h00 : bcd_inc(r_hsec);
    w_nxt_sec   = r_sec;
    w_nxt_min   = r_min;
    w_nxt_hr    = r_hr;
    if (w_hsec_wrap) w_nxt_sec = (r_sec == 8'h59) ? 8'h00 : bcd_inc(r_sec);
    if (w_sec_wrap)  w_nxt_min = (r_min == 8'h59) ? 8'h00 : bcd_inc(r_min);
    if (w_min_wrap)  w_nxt_hr  = (r_hr  == 8'h23) ? 8'h00 : bcd_inc(r_hr);
  end

  assign w_sec_carry = hundrethSec && w_hsec_wrap;
  assign w_set_load  = set_en && hm_ok(set_hr, set_min);
  assign w_alm_load  = alarm_wr && hm_ok(alarm_hr, alarm_min);
  // A valid time load wins over the tick, so it can never be the source of a match.
  assign w_match     = hundrethSec && !w_set_load &&
                       (w_nxt_hr == r_alm_hr) && (w_nxt_min == r_alm_min) &&
                       (w_nxt_sec == 8'h00) && (w_nxt_hsec == 8'h00);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_hr <= 8'h00; r_min <= 8'h00; r_sec <= 8'h00; r_hsec <= 8'h00;
    end else if (w_set_load) begin
      r_hr <= set_hr; r_min <= set_min; r_sec <= 8'h00; r_hsec <= 8'h00;
    end else if (hundrethSec) begin
      r_hr <= w_nxt_hr; r_min <= w_nxt_min; r_sec <= w_nxt_sec; r_hsec <= w_nxt_hsec;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_alm_hr  <= 8'h00;
      r_alm_min <= 8'h00;
    end else if (w_alm_load) begin
      r_alm_hr  <= alarm_hr;
      r_alm_min <= alarm_min;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_ring_nxt  = r_ring_cnt;
    w_snz_nxt   = r_snz_cnt;
    if (!alarm_arm) begin
      w_state_nxt = S_IDLE;
    end else begin
      unique case (r_state)
        S_IDLE: w_state_nxt = S_ARMED;
        S_ARMED: begin
          if (w_match) begin
            w_state_nxt = S_RINGING;
            w_ring_nxt  = RING_LOAD;
          end
        end
        S_RINGING: begin
          if (alarm_off) begin
            w_state_nxt = S_ARMED;
          end else if (snooze) begin
            w_state_nxt = S_SNOOZE;
            w_snz_nxt   = SNZ_LOAD;
          end else if (w_sec_carry) begin
            w_ring_nxt = (r_ring_cnt <= 16'd1) ? 16'd0 : r_ring_cnt - 16'd1;
            if (r_ring_cnt <= 16'd1) w_state_nxt = S_ARMED;
          end
        end
        S_SNOOZE: begin
          if (alarm_off) begin
            w_state_nxt = S_ARMED;
          end else if (w_sec_carry) begin
            w_snz_nxt = (r_snz_cnt <= 16'd1) ? 16'd0 : r_snz_cnt - 16'd1;
            if (r_snz_cnt <= 16'd1) begin
              w_state_nxt = S_RINGING;
              w_ring_nxt  = RING_LOAD;
            end
          end
        end
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_ring_cnt <= 16'd0;
      r_snz_cnt  <= 16'd0;
      r_ringing  <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_ring_cnt <= w_ring_nxt;
      r_snz_cnt  <= w_snz_nxt;
      r_ringing  <= (w_state_nxt == S_RINGING);
    end
  end

  assign hr      = r_hr;
  assign min     = r_min;
  assign sec     = r_sec;
  assign hsec    = r_hsec;
  assign ringing = r_ringing;
  assign state   = r_state;

endmodule

// File: tb/tb_tick_timekeeper.sv
// Bench for tick_timekeeper: expected time/state/ringing are queued as stimulus is driven,
// then popped and compared one edge later.
module tb_tick_timekeeper;

  logic       clk = 1'b0;
  logic       rst, hundrethSec, set_en, alarm_wr, alarm_arm, snooze, alarm_off;
  logic [7:0] set_hr, set_min, alarm_hr, alarm_min;
  logic [7:0] hr, min, sec, hsec;
  logic       ringing;
  logic [1:0] state;

  localparam logic [1:0] IDLE = 2'd0, ARMED = 2'd1, RINGING = 2'd2, SNOOZE = 2'd3;

  tick_timekeeper #(.SNOOZE_MIN(5), .RING_SEC(60)) dut (
    .clk(clk), .rst(rst), .hundrethSec(hundrethSec),
    .set_en(set_en), .set_hr(set_hr), .set_min(set_min),
    .alarm_wr(alarm_wr), .alarm_hr(alarm_hr), .alarm_min(alarm_min),
    .alarm_arm(alarm_arm), .snooze(snooze), .alarm_off(alarm_off),
    .hr(hr), .min(min), .sec(sec), .hsec(hsec),
    .ringing(ringing), .state(state)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  typedef struct {
    string       tag;
    int          sel;
    logic [31:0] exp;
  } sb_t;
  sb_t sb_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) $display("FAIL %s: got %h want %h", tag, obs, exp);
    else n_pass++;
  endtask

  task automatic sb_push(input string tag, input int sel, input logic [31:0] exp);
    sb_t e;
    e.tag = tag; e.sel = sel; e.exp = exp;
    sb_q.push_back(e);
  endtask

  task automatic expect_all(input string tag, input logic [31:0] t, input logic [1:0] st, input logic rg);
    sb_push({tag, ".time"}, 0, t);
    sb_push({tag, ".state"}, 1, {30'd0, st});
    sb_push({tag, ".ringing"}, 2, {31'd0, rg});
  endtask

  task automatic sb_check();
    sb_t e;
    logic [31:0] obs;
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      case (e.sel)
        0:       obs = {hr, min, sec, hsec};
        1:       obs = {30'd0, state};
        default: obs = {31'd0, ringing};
      endcase
      chk(e.tag, obs, e.exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    hundrethSec = 1'b1;
    step(n);
    hundrethSec = 1'b0;
  endtask

  task automatic set_time(input logic [7:0] h, input logic [7:0] m);
    set_hr = h; set_min = m; set_en = 1'b1;
    step(1);
    set_en = 1'b0;
  endtask

  task automatic wr_alarm(input logic [7:0] h, input logic [7:0] m);
    alarm_hr = h; alarm_min = m; alarm_wr = 1'b1;
    step(1);
    alarm_wr = 1'b0;
  endtask

  task automatic pulse(input logic s, input logic o);
    snooze = s; alarm_off = o;
    step(1);
    snooze = 1'b0; alarm_off = 1'b0;
  endtask

  initial begin
    rst = 1'b1; hundrethSec = 1'b0; set_en = 1'b0; alarm_wr = 1'b0;
    alarm_arm = 1'b0; snooze = 1'b0; alarm_off = 1'b0;
    set_hr = 8'h00; set_min = 8'h00; alarm_hr = 8'h00; alarm_min = 8'h00;

    expect_all("reset", 32'h00000000, IDLE, 1'b0);
    step(2); sb_check();
    rst = 1'b0;

    // Illegal loads leave the clock untouched
    expect_all("bad_hr24", 32'h00000000, IDLE, 1'b0);   set_time(8'h24, 8'h00); sb_check();
    sb_push("bad_min5A", 0, 32'h00000000);              set_time(8'h12, 8'h5A); sb_check();
    sb_push("bad_nib1A", 0, 32'h00000000);              set_time(8'h1A, 8'h10); sb_check();
    sb_push("bad_min60", 0, 32'h00000000);              set_time(8'h12, 8'h60); sb_check();

    sb_push("ticks150", 0, 32'h00000150);               ticks(150); sb_check();
    sb_push("set_vs_tick", 0, 32'h12340000);
    hundrethSec = 1'b1; set_time(8'h12, 8'h34); hundrethSec = 1'b0; sb_check();

    // 07:5A and 24:30 must be dropped; 07:30 stays the live alarm
    expect_all("alarm_wr", 32'h12340000, IDLE, 1'b0);   wr_alarm(8'h07, 8'h30); sb_check();
    wr_alarm(8'h07, 8'h5A); wr_alarm(8'h24, 8'h30);

    sb_push("arm", 1, {30'd0, ARMED});
    alarm_arm = 1'b1; step(1); sb_check();

    expect_all("set0729", 32'h07290000, ARMED, 1'b0);   set_time(8'h07, 8'h29); sb_check();
    expect_all("pre_match", 32'h07295999, ARMED, 1'b0); ticks(5999); sb_check();
    expect_all("match", 32'h07300000, RINGING, 1'b1);   ticks(1); sb_check();

    expect_all("snooze", 32'h07300000, SNOOZE, 1'b0);   pulse(1'b1, 1'b0); sb_check();
    ticks(1000);
    sb_push("snooze_again", 1, {30'd0, SNOOZE});        pulse(1'b1, 1'b0); sb_check();
    expect_all("snz_299", 32'h07345999, SNOOZE, 1'b0);  ticks(28999); sb_check();
    expect_all("snz_300", 32'h07350000, RINGING, 1'b1); ticks(1); sb_check();
    expect_all("off", 32'h07350000, ARMED, 1'b0);       pulse(1'b0, 1'b1); sb_check();

    set_time(8'h07, 8'h29);
    expect_all("ring2", 32'h07300000, RINGING, 1'b1);   ticks(6000); sb_check();
    expect_all("ring_59", 32'h07305999, RINGING, 1'b1); ticks(5999); sb_check();
    expect_all("ring_60", 32'h07310000, ARMED, 1'b0);   ticks(1); sb_check();

    set_time(8'h07, 8'h29);
    sb_push("ring3", 1, {30'd0, RINGING});              ticks(6000); sb_check();
    expect_all("snz_and_off", 32'h07300000, ARMED, 1'b0); pulse(1'b1, 1'b1); sb_check();

    set_time(8'h07, 8'h29);
    sb_push("ring4", 1, {30'd0, RINGING});              ticks(6000); sb_check();
    sb_push("snooze4", 1, {30'd0, SNOOZE});             pulse(1'b1, 1'b0); sb_check();
    expect_all("rst_snooze", 32'h00000000, IDLE, 1'b0);
    rst = 1'b1; snooze = 1'b1; set_en = 1'b1; set_hr = 8'h05; set_min = 8'h05;
    step(1);
    rst = 1'b0; snooze = 1'b0; set_en = 1'b0;
    sb_check();
    sb_push("rearm", 1, {30'd0, ARMED});                step(1); sb_check();

    // After reset the alarm is 00:00, so the midnight rollover rings
    expect_all("set2359", 32'h23590000, ARMED, 1'b0);   set_time(8'h23, 8'h59); sb_check();
    expect_all("midnight", 32'h00000000, RINGING, 1'b1); ticks(6000); sb_check();
    expect_all("hsec01", 32'h00000001, RINGING, 1'b1);  ticks(1); sb_check();
    expect_all("disarm", 32'h00000001, IDLE, 1'b0);
    alarm_arm = 1'b0; step(1); sb_check();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/tick_timekeeper.md
TICK_TIMEKEEPER -- requirements
Module: tick_timekeeper

Interface
REQ-001 SHALL have parameter SNOOZE_MIN, default 5, snooze length in minutes (legal 1..99).
REQ-002 SHALL have parameter RING_SEC, default 60, seconds of ringing before auto-stop (legal 1..3600).
REQ-003 SHALL have port clk  input  1  system clock (50MHz).
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port hundrethSec  input  1  one-clk tick, once per 1/100 s.
REQ-006 SHALL have port set_en  input  1  one-clk pulse, loads time-of-day from set_hr/set_min.
REQ-007 SHALL have ports set_hr, set_min  input  8 each  BCD hours/minutes to load.
REQ-008 SHALL have port alarm_wr  input  1  one-clk pulse, loads alarm time from alarm_hr/alarm_min.
REQ-009 SHALL have ports alarm_hr, alarm_min  input  8 each  BCD alarm hours/minutes.
REQ-010 SHALL have port alarm_arm  input  1  level; 1 = alarm enabled.
REQ-011 SHALL have ports snooze, alarm_off  input  1 each  one-clk pulses.
REQ-012 SHALL have ports hr, min, sec, hsec  output  8 each  BCD time-of-day.
REQ-013 SHALL have ports ringing  output  1 and state  output  2 (IDLE=0, ARMED=1, RINGING=2, SNOOZE=3).

Function
REQ-014 Time SHALL advance only on cycles with hundrethSec=1; hsec 00..99, sec/min 00..59, hr 00..23, all packed BCD.
REQ-015 Carries SHALL ripple in one cycle: a tick at 23:59:59.99 yields 00:00:00.00 at the next edge.
REQ-016 A second-carry event SHALL be a tick cycle with hsec=99; it drives all seconds-based counters.
REQ-017 set_en SHALL load hr/min from inputs and clear sec/hsec to 00 at the next edge, overriding a coincident tick.
REQ-018 A load with any BCD nibble >9, hr >23 or min >59 SHALL be ignored entirely (applies to set_en and alarm_wr).
REQ-019 alarm_wr SHALL update the alarm registers only; time-of-day and FSM state are unaffected.
REQ-020 Match event SHALL be a tick cycle whose next time value equals alarm_hr:alarm_min:00.00; a set_en load SHALL never create a match.
REQ-021 Any state SHALL go to IDLE at the next edge when alarm_arm=0 (highest priority after rst).
REQ-022 IDLE -> ARMED when alarm_arm=1.
REQ-023 ARMED -> RINGING on match event; ring counter loaded with RING_SEC.
REQ-024 RINGING: alarm_off -> ARMED; else snooze -> SNOOZE with snooze counter loaded SNOOZE_MIN*60; else ring counter decrements per second-carry and -> ARMED when it reaches 0.
REQ-025 alarm_off and snooze in the same cycle SHALL be treated as alarm_off.
REQ-026 SNOOZE: alarm_off -> ARMED; else snooze counter decrements per second-carry and -> RINGING (ring counter reloaded) when it reaches 0; further snooze pulses are ignored.
REQ-027 A match event while in RINGING or SNOOZE SHALL be ignored.
REQ-028 ringing SHALL be 1 exactly when state=RINGING (registered, no combinational path from inputs).
REQ-029 Snooze and ring counters SHALL be 16 bits wide, unsigned binary.

Reset
REQ-030 On rst=1 at an edge: time 00:00:00.00, alarm 00:00, state IDLE, ringing 0, counters 0; rst overrides all other inputs.
REQ-031 Reset asserted mid-RINGING or mid-SNOOZE SHALL abort to IDLE; re-arming requires alarm_arm=1 after rst deasserts.

Verification
REQ-032 set 23:59, apply 6000 ticks -> 00:00:00.00; one more tick -> hsec=01.
REQ-033 alarm 07:30, arm, set 07:29, 6000 ticks -> RINGING and ringing=1 on the edge hr:min becomes 07:30:00.00.
REQ-034 RINGING, snooze pulse -> SNOOZE; after 300 second-carries (SNOOZE_MIN=5) -> RINGING; alarm_off -> ARMED, ringing=0.
REQ-035 RINGING with no input for 60 second-carries -> ARMED; snooze+alarm_off same cycle -> ARMED.
REQ-036 set_en with set_hr=8'h24 or set_min=8'h5A -> time unchanged; set_en coincident with tick -> sec=00, hsec=00.
REQ-037 rst during SNOOZE -> IDLE, time 00:00:00.00, alarm 00:00 next edge; alarm_arm low in RINGING -> IDLE next edge.
